// File: rtl/w5300_host_bus_ctrl_pkg.sv
// rtl/w5300_host_bus_ctrl_pkg.sv - W5300 host bus constants, state type and default timing
package W5300;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    // Default phase lengths in 10 ns cycles (100 MHz clock)
    localparam int unsigned DEF_SETUP_CYC   = 1;
    localparam int unsigned DEF_STROBE_CYC  = 7;
    localparam int unsigned DEF_HOLD_CYC    = 1;
    localparam int unsigned DEF_RECOVER_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } host_bus_state_t;

endpackage

// File: rtl/w5300_host_bus_ctrl_sync_2ff.sv
// rtl/w5300_host_bus_ctrl_sync_2ff.sv - generic 2-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w5300_host_bus_ctrl.sv
// rtl/w5300_host_bus_ctrl.sv - single 16-bit register access engine for the W5300 direct-address host bus
module w5300_host_bus_ctrl
    import W5300::*;
#(
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
    parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_state,
    output logic        busy,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_dq_o,
    output logic        bus_dq_oe,
    input  logic [15:0] bus_dq_i,
    output logic        bus_cs_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    input  logic        bus_int_n,
    output logic        irq
);

    localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);

    host_bus_state_t state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            accept, capture, done;
    logic            rw_q, rw_sel, in_access;
    logic            int_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // End of Recover doubles as the Idle sampling point so a held req gets full throughput
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                    accept    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LD;
                    capture   = (rw_q == RD);
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = RECOVER_LD;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt == 8'd0) begin
                    if (req) begin
                        state_nxt = ST_SETUP;
                        cnt_nxt   = SETUP_LD;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign rw_sel    = accept ? addr[10] : rw_q;
    assign in_access = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);

    // Pins are registered from the next state so they line up with the phase they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= RD;
            bus_addr  <= 10'd0;
            bus_dq_o  <= 16'd0;
            rd_data   <= 16'd0;
            op_state  <= 1'b0;
            busy      <= 1'b0;
            bus_cs_n  <= 1'b1;
            bus_rd_n  <= 1'b1;
            bus_wr_n  <= 1'b1;
            bus_dq_oe <= 1'b0;
        end else begin
            if (accept) begin
                rw_q     <= addr[10];
                bus_addr <= addr[9:0];
                bus_dq_o <= wr_data;
            end
            if (capture) begin
                rd_data <= bus_dq_i;
            end
            op_state  <= done;
            busy      <= (state_nxt != ST_IDLE);
            bus_cs_n  <= !in_access;
            bus_rd_n  <= !((state_nxt == ST_STROBE) && (rw_sel == RD));
            bus_wr_n  <= !((state_nxt == ST_STROBE) && (rw_sel == WR));
            bus_dq_oe <= in_access && (rw_sel == WR);
        end
    end

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus_int_n),
        .q    (int_sync)
    );

    assign irq = !int_sync;

endmodule

// File: tb/tb_w5300_host_bus_ctrl.sv
// tb/tb_w5300_host_bus_ctrl.sv - randomized self-checking bench for w5300_host_bus_ctrl
module tb_w5300_host_bus_ctrl;
    import W5300::*;

    localparam int TS  = 1;
    localparam int TST = 7;
    localparam int TH  = 1;
    localparam int TR  = 3;
    localparam int LAT = TS + TST + TH + 1;
    localparam int CS_LOW = TS + TST + TH;
    localparam int PERIOD = TS + TST + TH + TR;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [10:0] addr = 11'd0;
    logic [15:0] wr_data = 16'd0;
    logic [15:0] rd_data;
    logic        op_state;
    logic        busy;
    logic [9:0]  bus_addr;
    logic [15:0] bus_dq_o;
    logic        bus_dq_oe;
    logic [15:0] bus_dq_i;
    logic        bus_cs_n, bus_rd_n, bus_wr_n;
    logic        bus_int_n = 1'b1;
    logic        irq;

    int errors = 0;
    int checks = 0;

    w5300_host_bus_ctrl #(
        .SETUP_CYC(TS), .STROBE_CYC(TST), .HOLD_CYC(TH), .RECOVER_CYC(TR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .op_state(op_state), .busy(busy),
        .bus_addr(bus_addr), .bus_dq_o(bus_dq_o), .bus_dq_oe(bus_dq_oe),
        .bus_dq_i(bus_dq_i), .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n),
        .bus_wr_n(bus_wr_n), .bus_int_n(bus_int_n), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Power-on register contents of the modelled W5300
    function automatic logic [15:0] dflt(input logic [9:0] a);
        return {a[5:0], a} ^ 16'hA5C3;
    endfunction

    // Bus-side W5300 model and activity monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           op_q[$];
    logic [9:0]   addr_q[$];
    int           hi_q[$];
    int           cs_low = 0, wr_low = 0, rd_low = 0, oe_hi = 0;
    int           overlap_err = 0, oe_err = 0, hi_run = 0;
    logic         prev_cs = 1'b1, prev_wr = 1'b1;
    logic [15:0]  bmem [int];

    always @(negedge clk) begin
        if (rst_n && !bus_rd_n)
            bus_dq_i = bmem.exists(int'(bus_addr)) ? bmem[int'(bus_addr)] : dflt(bus_addr);
        else
            bus_dq_i = 16'($urandom);
        if (!rst_n) begin
            prev_cs = 1'b1;
            prev_wr = 1'b1;
            hi_run  = 0;
        end else begin
            if (!bus_cs_n) begin
                cs_low++;
                if (prev_cs) begin
                    addr_q.push_back(bus_addr);
                    hi_q.push_back(hi_run);
                    hi_run = 0;
                end
            end else begin
                hi_run++;
            end
            if (!bus_wr_n) wr_low++;
            if (!bus_rd_n) rd_low++;
            if (bus_dq_oe) oe_hi++;
            if (!bus_wr_n && !bus_rd_n) overlap_err++;
            if (bus_cs_n && bus_dq_oe) oe_err++;
            if (!prev_wr && bus_wr_n) bmem[int'(bus_addr)] = bus_dq_o;
            if (op_state) op_q.push_back(cyc);
            prev_cs = bus_cs_n;
            prev_wr = bus_wr_n;
        end
    end

    // Reference register file as seen by the initiator
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input logic [9:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] bus_val(input logic [9:0] a);
        return bmem.exists(int'(a)) ? bmem[int'(a)] : dflt(a);
    endfunction

    // One access, req dropped during Setup; checks shape, latency and data
    task automatic single(input logic rw, input logic [9:0] a, input logic [15:0] d, input string tag);
        int ob, ab, cs0, wr0, rd0, oe0, t0;
        logic [15:0] rd_prev;
        @(negedge clk);
        ob = op_q.size(); ab = addr_q.size();
        cs0 = cs_low; wr0 = wr_low; rd0 = rd_low; oe0 = oe_hi;
        t0 = cyc; rd_prev = rd_data;
        addr = {rw, a}; wr_data = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        repeat (PERIOD) @(negedge clk);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_ops"}, op_q.size() - ob, 1);
        if (op_q.size() > ob) check({tag, "_latency"}, op_q[ob] - t0, LAT);
        check({tag, "_accesses"}, addr_q.size() - ab, 1);
        if (addr_q.size() > ab) check({tag, "_addr"}, addr_q[ab], a);
        check({tag, "_cs_low"}, cs_low - cs0, CS_LOW);
        check({tag, "_wr_low"}, wr_low - wr0, (rw == WR) ? TST : 0);
        check({tag, "_rd_low"}, rd_low - rd0, (rw == RD) ? TST : 0);
        check({tag, "_oe"}, oe_hi - oe0, (rw == WR) ? CS_LOW : 0);
        if (rw == WR) begin
            ref_mem[int'(a)] = d;
            check({tag, "_wdata"}, bus_val(a), d);
            check({tag, "_rd_kept"}, rd_data, rd_prev);
        end else begin
            check({tag, "_rdata"}, rd_data, ref_rd(a));
        end
    endtask

    initial begin
        logic [9:0]  ba[14];
        logic [15:0] bd[14];
        int k, ob, ab, hb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", bus_cs_n, 1'b1);
        check("rst_rd_n", bus_rd_n, 1'b1);
        check("rst_wr_n", bus_wr_n, 1'b1);
        check("rst_oe", bus_dq_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_op", op_state, 1'b0);
        check("rst_rd_data", rd_data, 16'd0);
        check("rst_irq", irq, 1'b0);
        check("rst_bus_addr", bus_addr, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        single(WR, 10'h000, 16'h3800, "wr0");
        single(WR, 10'h208, 16'h0013, "wr208");
        single(RD, 10'h208, 16'h0000, "rd208");
        check("rd208_val", rd_data, 16'h0013);

        for (int i = 0; i < 8; i++) begin
            logic rw;
            logic [9:0] a;
            rw = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 15)) << 1;
            single(rw, a, 16'($urandom), "rnd");
        end

        // Back-to-back writes with req held high
        for (int i = 0; i < 14; i++) begin
            ba[i] = 10'($urandom);
            bd[i] = 16'($urandom);
        end
        @(negedge clk);
        ob = op_q.size(); ab = addr_q.size(); hb = hi_q.size(); k = 0;
        addr = {WR, ba[0]}; wr_data = bd[0]; req = 1'b1;
        for (int i = 0; i < 14 * PERIOD + 60 && !(k == 14 && !busy); i++) begin
            @(negedge clk);
            if (op_state) begin
                ref_mem[int'(ba[k])] = bd[k];
                k++;
                if (k < 14) begin
                    addr = {WR, ba[k]}; wr_data = bd[k];
                end else begin
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        repeat (PERIOD) @(negedge clk);
        check("b2b_ops", op_q.size() - ob, 14);
        check("b2b_accesses", addr_q.size() - ab, 14);
        for (int j = 1; j < 14; j++) begin
            if (op_q.size() > ob + j) check("b2b_period", op_q[ob + j] - op_q[ob + j - 1], PERIOD);
            if (hi_q.size() > hb + j) check("b2b_cs_high", 32'(hi_q[hb + j] >= TR), 1);
        end
        for (int j = 0; j < 14; j++) begin
            if (addr_q.size() > ab + j) check("b2b_addr", addr_q[ab + j], ba[j]);
            check("b2b_wdata", bus_val(ba[j]), ref_rd(ba[j]));
        end

        // Reset in the middle of a read strobe
        @(negedge clk);
        ob = op_q.size();
        addr = {RD, 10'h155}; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 20 && bus_rd_n; i++) @(negedge clk);
        check("rst_mid_in_strobe", bus_rd_n, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", bus_cs_n, 1'b1);
        check("rst_mid_rd_n", bus_rd_n, 1'b1);
        check("rst_mid_wr_n", bus_wr_n, 1'b1);
        check("rst_mid_oe", bus_dq_oe, 1'b0);
        check("rst_mid_rd_data", rd_data, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_no_op", op_q.size() - ob, 0);
        check("rst_mid_idle", busy, 1'b0);
        single(RD, 10'h000, 16'h0000, "post_rst_rd");
        single(WR, 10'h1F0, 16'hBEEF, "post_rst_wr");

        // Interrupt synchronizer
        @(posedge clk);
        #2 bus_int_n = 1'b0;
        @(posedge clk); #1 check("irq_1edge_low", irq, 1'b0);
        @(posedge clk); #1 check("irq_2edge_high", irq, 1'b1);
        #1 bus_int_n = 1'b1;
        @(posedge clk); #1 check("irq_1edge_keep", irq, 1'b1);
        @(posedge clk); #1 check("irq_2edge_low", irq, 1'b0);

        check("no_strobe_overlap", overlap_err, 0);
        check("no_oe_outside_cs", oe_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
